// File: rtl/fifo_mon_pkg.sv
// Shared definitions for the read-side frame checker: error bit layout,
// per-port FSM states and the beats-per-frame helper.
package fifo_mon_pkg;

  localparam int ERR_TRUNC    = 0;
  localparam int ERR_ORPHAN   = 1;
  localparam int ERR_ZERO_LEN = 2;
  localparam int ERR_TAG      = 3;
  localparam int ERR_W        = 4;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } port_state_e;

  // Number of bus beats needed to carry num bytes on a den-byte bus.
  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/fifo_frame_port_checker.sv
// Single-port frame tracker: sop/len framing FSM, tag sequencing check,
// saturating clean-frame statistics and sticky error flags.
module fifo_frame_port_checker
  import fifo_mon_pkg::*;
#(
  parameter int FRAME_DATA_WIDTH = 1024,
  parameter int LEN_WIDTH        = 16,
  parameter int TAG_WIDTH        = 8,
  parameter int CNT_WIDTH        = 32,
  parameter int TAG_CHECK_EN     = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 stat_clr,
  input  logic                 enb,
  input  logic                 sop,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic [TAG_WIDTH-1:0] tag,
  output logic                 frame_done,
  output logic [LEN_WIDTH-1:0] frame_done_len,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic [CNT_WIDTH-1:0] byte_cnt,
  output logic [ERR_W-1:0]     err_sticky,
  output logic                 err_pulse
);

  localparam int unsigned BYTES = FRAME_DATA_WIDTH / 8;
  localparam int BW = LEN_WIDTH + 1;
  localparam int SW = ((CNT_WIDTH > LEN_WIDTH) ? CNT_WIDTH : LEN_WIDTH) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  port_state_e          state_reg, state_next;
  logic [BW-1:0]        rem_reg, rem_next;
  logic [LEN_WIDTH-1:0] len_reg, len_next;
  logic [TAG_WIDTH-1:0] exp_tag_reg, exp_tag_next;
  logic                 exp_valid_reg, exp_valid_next;
  logic                 frame_done_reg;
  logic [LEN_WIDTH-1:0] done_len_reg;
  logic [CNT_WIDTH-1:0] frame_cnt_reg, frame_cnt_next;
  logic [CNT_WIDTH-1:0] byte_cnt_reg, byte_cnt_next;
  logic [ERR_W-1:0]     err_reg;
  logic                 err_pulse_reg;

  logic [BW-1:0]        beats;
  logic                 complete;
  logic [LEN_WIDTH-1:0] complete_len;
  logic [ERR_W-1:0]     err_set;
  logic [SW-1:0]        byte_sum;

  assign beats = BW'(ceil_div(32'(len), BYTES));

  always_comb begin
    state_next     = state_reg;
    rem_next       = rem_reg;
    len_next       = len_reg;
    exp_tag_next   = exp_tag_reg;
    exp_valid_next = exp_valid_reg;
    complete       = 1'b0;
    complete_len   = len_reg;
    err_set        = '0;

    if (enb) begin
      if (sop) begin
        // A sop inside a frame abandons the old frame, then is handled as a fresh sop.
        if (state_reg == ST_IN_FRAME) err_set[ERR_TRUNC] = 1'b1;
        if (len == '0) begin
          err_set[ERR_ZERO_LEN] = 1'b1;
          state_next            = ST_IDLE;
        end else begin
          if (TAG_CHECK_EN != 0 && exp_valid_reg && tag != exp_tag_reg)
            err_set[ERR_TAG] = 1'b1;
          exp_tag_next   = tag + TAG_WIDTH'(1);
          exp_valid_next = 1'b1;
          len_next       = len;
          if (beats == BW'(1)) begin
            complete     = 1'b1;
            complete_len = len;
            state_next   = ST_IDLE;
          end else begin
            rem_next   = beats - BW'(1);
            state_next = ST_IN_FRAME;
          end
        end
      end else if (state_reg == ST_IDLE) begin
        err_set[ERR_ORPHAN] = 1'b1;
      end else begin
        rem_next = rem_reg - BW'(1);
        if (rem_reg == BW'(1)) begin
          complete   = 1'b1;
          state_next = ST_IDLE;
        end
      end
    end
  end

  // Saturating statistics: an overflowing sum pins the counter at all-ones.
  always_comb begin
    byte_sum       = SW'(byte_cnt_reg) + SW'(complete_len);
    byte_cnt_next  = (byte_sum > SW'(CNT_MAX)) ? CNT_MAX : byte_sum[CNT_WIDTH-1:0];
    frame_cnt_next = (frame_cnt_reg == CNT_MAX) ? CNT_MAX : frame_cnt_reg + CNT_WIDTH'(1);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg      <= ST_IDLE;
      rem_reg        <= '0;
      len_reg        <= '0;
      exp_tag_reg    <= '0;
      exp_valid_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      done_len_reg   <= '0;
      frame_cnt_reg  <= '0;
      byte_cnt_reg   <= '0;
      err_reg        <= '0;
      err_pulse_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rem_reg        <= rem_next;
      len_reg        <= len_next;
      exp_tag_reg    <= exp_tag_next;
      frame_done_reg <= complete;
      err_pulse_reg  <= |err_set;
      if (complete) done_len_reg <= complete_len;
      if (stat_clr) begin
        frame_cnt_reg <= '0;
        byte_cnt_reg  <= '0;
        err_reg       <= '0;
        exp_valid_reg <= 1'b0;
      end else begin
        exp_valid_reg <= exp_valid_next;
        err_reg       <= err_reg | err_set;
        if (complete) begin
          frame_cnt_reg <= frame_cnt_next;
          byte_cnt_reg  <= byte_cnt_next;
        end
      end
    end
  end

  assign frame_done     = frame_done_reg;
  assign frame_done_len = done_len_reg;
  assign frame_cnt      = frame_cnt_reg;
  assign byte_cnt       = byte_cnt_reg;
  assign err_sticky     = err_reg;
  assign err_pulse      = err_pulse_reg;

endmodule

// File: rtl/fifo_frame_checker.sv
// Multi-port read-side frame checker: one independent port checker per
// FIFO read port; this level only slices the packed buses.
module fifo_frame_checker
  import fifo_mon_pkg::*;
#(
  parameter int FRAME_DATA_WIDTH = 1024,
  parameter int PORTS            = 4,
  parameter int LEN_WIDTH        = 16,
  parameter int TAG_WIDTH        = 8,
  parameter int CNT_WIDTH        = 32,
  parameter int TAG_CHECK_EN     = 1
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  input  logic                         stat_clr,
  input  logic [PORTS-1:0]             read_frame_enb,
  input  logic [PORTS-1:0]             read_frame_sop,
  input  logic [PORTS*LEN_WIDTH-1:0]   read_frame_len,
  input  logic [PORTS*TAG_WIDTH-1:0]   read_frame_tag,
  output logic [PORTS-1:0]             frame_done,
  output logic [PORTS*LEN_WIDTH-1:0]   frame_done_len,
  output logic [PORTS*CNT_WIDTH-1:0]   frame_cnt,
  output logic [PORTS*CNT_WIDTH-1:0]   byte_cnt,
  output logic [PORTS*ERR_W-1:0]       err_sticky,
  output logic [PORTS-1:0]             err_pulse
);

  for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
    fifo_frame_port_checker #(
      .FRAME_DATA_WIDTH (FRAME_DATA_WIDTH),
      .LEN_WIDTH        (LEN_WIDTH),
      .TAG_WIDTH        (TAG_WIDTH),
      .CNT_WIDTH        (CNT_WIDTH),
      .TAG_CHECK_EN     (TAG_CHECK_EN)
    ) u_port (
      .sys_clk        (sys_clk),
      .sys_rst_n      (sys_rst_n),
      .stat_clr       (stat_clr),
      .enb            (read_frame_enb[gi]),
      .sop            (read_frame_sop[gi]),
      .len            (read_frame_len[gi*LEN_WIDTH +: LEN_WIDTH]),
      .tag            (read_frame_tag[gi*TAG_WIDTH +: TAG_WIDTH]),
      .frame_done     (frame_done[gi]),
      .frame_done_len (frame_done_len[gi*LEN_WIDTH +: LEN_WIDTH]),
      .frame_cnt      (frame_cnt[gi*CNT_WIDTH +: CNT_WIDTH]),
      .byte_cnt       (byte_cnt[gi*CNT_WIDTH +: CNT_WIDTH]),
      .err_sticky     (err_sticky[gi*ERR_W +: ERR_W]),
      .err_pulse      (err_pulse[gi])
    );
  end

endmodule

// File: tb/tb_fifo_frame_checker.sv
// Directed bench: main 4-port instance for framing/tag/error behaviour and a
// narrow 1-port instance (4-bit counters, 8-byte bus) for saturation.
module tb_fifo_frame_checker;

  logic         sys_clk = 1'b0;
  logic         sys_rst_n = 1'b0;
  logic         stat_clr = 1'b0;
  logic [3:0]   enb = '0, sop = '0;
  logic [63:0]  len = '0;
  logic [31:0]  tag = '0;
  logic [3:0]   frame_done, err_pulse;
  logic [63:0]  frame_done_len;
  logic [127:0] frame_cnt, byte_cnt;
  logic [15:0]  err_sticky;

  logic       s_enb = 1'b0, s_sop = 1'b0;
  logic [3:0] s_len = '0, s_tag = '0;
  logic       s_done, s_pulse;
  logic [3:0] s_done_len, s_fcnt, s_bcnt, s_err;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  fifo_frame_checker dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .stat_clr(stat_clr),
    .read_frame_enb(enb), .read_frame_sop(sop), .read_frame_len(len), .read_frame_tag(tag),
    .frame_done(frame_done), .frame_done_len(frame_done_len), .frame_cnt(frame_cnt),
    .byte_cnt(byte_cnt), .err_sticky(err_sticky), .err_pulse(err_pulse)
  );

  fifo_frame_checker #(
    .FRAME_DATA_WIDTH(64), .PORTS(1), .LEN_WIDTH(4), .TAG_WIDTH(4), .CNT_WIDTH(4), .TAG_CHECK_EN(1)
  ) sdut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .stat_clr(stat_clr),
    .read_frame_enb(s_enb), .read_frame_sop(s_sop), .read_frame_len(s_len), .read_frame_tag(s_tag),
    .frame_done(s_done), .frame_done_len(s_done_len), .frame_cnt(s_fcnt),
    .byte_cnt(s_bcnt), .err_sticky(s_err), .err_pulse(s_pulse)
  );

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic beat(input int p, input logic s, input logic [15:0] l, input logic [7:0] t);
    enb[p] = 1'b1;
    sop[p] = s;
    len[p*16 +: 16] = l;
    tag[p*8 +: 8] = t;
  endtask

  task automatic sbeat(input logic s, input logic [3:0] l, input logic [3:0] t);
    s_enb = 1'b1;
    s_sop = s;
    s_len = l;
    s_tag = t;
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge sys_clk);
    #1;
    enb = '0;
    sop = '0;
    s_enb = 1'b0;
    s_sop = 1'b0;
    stat_clr = 1'b0;
  endtask

  function automatic logic [31:0] fcnt(input int p);
    return frame_cnt[p*32 +: 32];
  endfunction
  function automatic logic [31:0] bcnt(input int p);
    return byte_cnt[p*32 +: 32];
  endfunction
  function automatic logic [3:0] errs(input int p);
    return err_sticky[p*4 +: 4];
  endfunction
  function automatic logic [15:0] dlen(input int p);
    return frame_done_len[p*16 +: 16];
  endfunction

  initial begin
    tick();
    tick();
    chk("reset_frame_done", frame_done, 4'b0);
    chk("reset_frame_cnt", frame_cnt, '0);
    chk("reset_byte_cnt", byte_cnt, '0);
    chk("reset_err_sticky", err_sticky, '0);
    chk("reset_err_pulse", err_pulse, 4'b0);
    sys_rst_n = 1'b1;
    tick();

    // Port 0: 300 bytes over 3 back-to-back beats
    beat(0, 1'b1, 16'd300, 8'd5); tick();
    chk("p0_beat1_no_done", frame_done, 4'b0);
    beat(0, 1'b0, 16'd0, 8'd0); tick();
    chk("p0_beat2_no_done", frame_done, 4'b0);
    beat(0, 1'b0, 16'd0, 8'd0); tick();
    $display("txn p0 frame len=300 tag=5 done=%b", frame_done);
    chk("p0_done", frame_done, 4'b0001);
    chk("p0_done_len", dlen(0), 16'd300);
    chk("p0_frame_cnt", fcnt(0), 32'd1);
    chk("p0_byte_cnt", bcnt(0), 32'd300);
    chk("p0_err_sticky", err_sticky, 16'h0);
    tick();
    chk("p0_done_pulse_ends", frame_done, 4'b0);

    // Port 2: single-beat 128, then 129 over 2 beats with a gap
    beat(2, 1'b1, 16'd128, 8'd0); tick();
    $display("txn p2 frame len=128 done=%b", frame_done);
    chk("p2_single_done", frame_done, 4'b0100);
    chk("p2_single_len", dlen(2), 16'd128);
    beat(2, 1'b1, 16'd129, 8'd1); tick();
    chk("p2_sop2_no_done", frame_done, 4'b0);
    tick();
    tick();
    chk("p2_gap_no_done", frame_done, 4'b0);
    beat(2, 1'b0, 16'd0, 8'd0); tick();
    $display("txn p2 frame len=129 done=%b byte_cnt=%0d", frame_done, bcnt(2));
    chk("p2_second_done", frame_done, 4'b0100);
    chk("p2_second_len", dlen(2), 16'd129);
    chk("p2_byte_cnt", bcnt(2), 32'd257);
    chk("p2_frame_cnt", fcnt(2), 32'd2);

    // Port 1: 384-byte frame truncated by a new 64-byte sop
    beat(1, 1'b1, 16'd384, 8'd9); tick();
    chk("p1_no_pulse_yet", err_pulse, 4'b0);
    beat(1, 1'b1, 16'd64, 8'd10); tick();
    $display("txn p1 trunc err_pulse=%b err=%b", err_pulse, errs(1));
    chk("p1_trunc_pulse", err_pulse, 4'b0010);
    chk("p1_trunc_sticky", errs(1), 4'b0001);
    chk("p1_new_frame_done", frame_done, 4'b0010);
    chk("p1_frame_cnt", fcnt(1), 32'd1);
    chk("p1_byte_cnt", bcnt(1), 32'd64);
    tick();
    chk("p1_pulse_once", err_pulse, 4'b0);

    // Port 3: tag wrap 254,255,0 legal; 7 mismatches; 8 resynchronised
    beat(3, 1'b1, 16'd10, 8'd254); tick();
    chk("p3_tag254", err_pulse, 4'b0);
    beat(3, 1'b1, 16'd10, 8'd255); tick();
    chk("p3_tag255", err_pulse, 4'b0);
    beat(3, 1'b1, 16'd10, 8'd0); tick();
    chk("p3_tag0_wrap", err_pulse, 4'b0);
    beat(3, 1'b1, 16'd10, 8'd7); tick();
    $display("txn p3 tag=7 err_pulse=%b err=%b", err_pulse, errs(3));
    chk("p3_tag7_pulse", err_pulse, 4'b1000);
    chk("p3_tag7_sticky", errs(3), 4'b1000);
    beat(3, 1'b1, 16'd10, 8'd8); tick();
    chk("p3_tag8_resync", err_pulse, 4'b0);
    chk("p3_frame_cnt", fcnt(3), 32'd5);
    chk("p3_byte_cnt", bcnt(3), 32'd50);

    // Orphan on port 0 and zero-length sop on port 1 together
    beat(0, 1'b0, 16'd0, 8'd0);
    beat(1, 1'b1, 16'd0, 8'd11);
    tick();
    $display("txn orphan/zero_len err_pulse=%b", err_pulse);
    chk("orphan_zero_pulse", err_pulse, 4'b0011);
    chk("p0_orphan_sticky", errs(0), 4'b0010);
    chk("p1_zero_sticky", errs(1), 4'b0101);
    chk("p0_cnt_unchanged", fcnt(0), 32'd1);
    chk("p1_cnt_unchanged", fcnt(1), 32'd1);
    chk("zero_no_done", frame_done, 4'b0);

    // Narrow instance: byte_cnt overflow then frame_cnt saturation
    sbeat(1'b1, 4'd8, 4'd0); tick();
    chk("s_bcnt_8", s_bcnt, 4'd8);
    sbeat(1'b1, 4'd8, 4'd1); tick();
    chk("s_bcnt_sat", s_bcnt, 4'hF);
    chk("s_fcnt_2", s_fcnt, 4'd2);
    for (int i = 2; i < 15; i++) begin
      sbeat(1'b1, 4'd1, 4'(i)); tick();
    end
    chk("s_fcnt_full", s_fcnt, 4'hF);
    sbeat(1'b1, 4'd1, 4'd15); tick();
    $display("txn narrow saturate fcnt=%0h bcnt=%0h done=%b", s_fcnt, s_bcnt, s_done);
    chk("s_fcnt_holds", s_fcnt, 4'hF);
    chk("s_bcnt_holds", s_bcnt, 4'hF);
    chk("s_done_still", s_done, 1'b1);
    chk("s_no_err", s_err, 4'h0);

    // stat_clr clears counters and sticky errors
    stat_clr = 1'b1; tick();
    $display("txn stat_clr");
    chk("clr_frame_cnt", frame_cnt, '0);
    chk("clr_byte_cnt", byte_cnt, '0);
    chk("clr_err_sticky", err_sticky, '0);
    chk("clr_s_fcnt", s_fcnt, 4'h0);
    // A completion coinciding with stat_clr is not counted but still pulses
    stat_clr = 1'b1;
    beat(0, 1'b1, 16'd10, 8'd99); tick();
    chk("clr_wins_done", frame_done, 4'b0001);
    chk("clr_wins_cnt", fcnt(0), 32'd0);
    // Expected tag invalidated: arbitrary tag on port 3 is not an error
    beat(3, 1'b1, 16'd10, 8'd50); tick();
    chk("clr_tag_fresh", err_pulse, 4'b0);
    chk("clr_tag_counted", fcnt(3), 32'd1);

    // Asynchronous reset mid-frame while a done pulse is live
    beat(2, 1'b1, 16'd128, 8'd0);
    beat(0, 1'b1, 16'd300, 8'd1);
    tick();
    chk("pre_rst_done", frame_done, 4'b0100);
    #2 sys_rst_n = 1'b0;
    #1;
    $display("txn async reset mid-frame");
    chk("rst_frame_done", frame_done, 4'b0);
    chk("rst_done_len", frame_done_len, '0);
    chk("rst_frame_cnt", frame_cnt, '0);
    chk("rst_byte_cnt", byte_cnt, '0);
    chk("rst_err_sticky", err_sticky, '0);
    sys_rst_n = 1'b1;
    tick();
    chk("rst_no_err", err_pulse, 4'b0);
    // Dropped frame: a continuation beat is now an orphan
    beat(0, 1'b0, 16'd0, 8'd0); tick();
    chk("rst_dropped_orphan", errs(0), 4'b0010);
    chk("rst_dropped_pulse", err_pulse, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
